// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - cuts an unframed AXI-stream into header-prefixed packets
module axis_packetizer #(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [P_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    pkt_done,
    output logic                    busy
);

    localparam int SEQ_W = P_DATA_WIDTH - P_LEN_WIDTH;
    localparam logic [P_LEN_WIDTH-1:0] LEN_ONE = P_LEN_WIDTH'(1);
    localparam logic [SEQ_W-1:0]       SEQ_ONE = SEQ_W'(1);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t                  state, state_nxt;
    logic [SEQ_W-1:0]        seq, seq_nxt;
    logic [P_LEN_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
    logic [P_LEN_WIDTH-1:0]  len_q, len_q_nxt;

    logic                    tvalid_nxt;
    logic [P_DATA_WIDTH-1:0] tdata_nxt;
    logic                    tlast_nxt;
    logic                    done_nxt;
    logic                    out_free;
    logic                    last_beat;

    // The output stage can take a new word when empty or being drained this cycle.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == PAYLOAD) && out_free;
    assign busy          = (state == PAYLOAD);
    // Comparing against len_q-1 keeps beat_cnt within P_LEN_WIDTH for max-length packets.
    assign last_beat     = (beat_cnt == (len_q - LEN_ONE));

    // Control state: FSM, sequence number, beat counter and latched packet length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            seq      <= '0;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            state    <= state_nxt;
            seq      <= seq_nxt;
            beat_cnt <= beat_cnt_nxt;
            len_q    <= len_q_nxt;
        end
    end

    // Registered output stage; pkt_done rides along with the first showing of the tlast beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            pkt_done      <= 1'b0;
        end else begin
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tlast  <= tlast_nxt;
            pkt_done      <= done_nxt;
        end
    end

    // Next-state and output-register load decisions.
    always_comb begin
        state_nxt    = state;
        seq_nxt      = seq;
        beat_cnt_nxt = beat_cnt;
        len_q_nxt    = len_q;
        done_nxt     = 1'b0;
        // Hold the presented word while stalled, otherwise drop valid unless reloaded below.
        tvalid_nxt   = out_free ? 1'b0 : m_axis_tvalid;
        tlast_nxt    = out_free ? 1'b0 : m_axis_tlast;
        tdata_nxt    = m_axis_tdata;

        case (state)
            IDLE: begin
                // The pending input word only starts the packet; it is consumed in PAYLOAD.
                if (s_axis_tvalid && (cfg_pkt_len != '0) && out_free) begin
                    tvalid_nxt   = 1'b1;
                    tdata_nxt    = {seq, cfg_pkt_len};
                    tlast_nxt    = 1'b0;
                    len_q_nxt    = cfg_pkt_len;
                    beat_cnt_nxt = '0;
                    state_nxt    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    tvalid_nxt   = 1'b1;
                    tdata_nxt    = s_axis_tdata;
                    tlast_nxt    = last_beat;
                    beat_cnt_nxt = beat_cnt + LEN_ONE;
                    if (last_beat) begin
                        seq_nxt   = seq + SEQ_ONE;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - scoreboard bench for axis_packetizer
module tb_axis_packetizer;

    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk;
    logic          rst;
    logic [LW-1:0] cfg_pkt_len;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          pkt_done;
    logic          busy;

    axis_packetizer #(.P_DATA_WIDTH(DW), .P_LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_pkt_len   (cfg_pkt_len),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_done      (pkt_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [DW:0]   exp_q[$];
    int            cyc_q[$];
    int            cyc = 0;
    int            done_cnt = 0;
    int            last_cnt = 0;
    int            acc_cnt = 0;
    logic          mon_en = 1'b0;
    logic          prev_free = 1'b1;
    logic          stalled = 1'b0;
    logic [DW:0]   held;
    logic [DW:0]   exp_word;
    logic [7:0]    exp_seq = 8'd0;
    logic [DW-1:0] next_word = 16'd1;
    logic          bp_mode = 1'b0;
    logic          tready_fix = 1'b1;
    int            a0, d0, l0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Downstream ready: fixed level or toggling every cycle for backpressure.
    always @(posedge clk) begin
        #1;
        m_axis_tready = bp_mode ? ~m_axis_tready : tready_fix;
    end

    // Output monitor: scoreboard pops, AXI stability and pkt_done alignment.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("pkt_done_align", {31'd0, pkt_done},
                {31'd0, (m_axis_tvalid && prev_free && m_axis_tlast)});
            if (stalled)
                chk("stall_stable", {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {14'd0, 1'b1, held});
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    assert (exp_q.size() != 0) else begin
                        bad++;
                        $error("FAIL unexpected_beat observed=%0h expected=none",
                               {m_axis_tlast, m_axis_tdata});
                    end
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("beat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, exp_word});
                end
                cyc_q.push_back(cyc);
                if (m_axis_tlast) last_cnt++;
            end
            if (pkt_done) done_cnt++;
            if (s_axis_tvalid && s_axis_tready) acc_cnt++;
        end
        stalled   = m_axis_tvalid && !m_axis_tready;
        held      = {m_axis_tlast, m_axis_tdata};
        prev_free = !m_axis_tvalid || m_axis_tready;
    end

    task automatic exp_hdr(input logic [7:0] len);
        exp_q.push_back({1'b0, exp_seq, len});
        exp_seq = exp_seq + 8'd1;
    endtask

    // Feed n words; word index 'last' is expected with tlast; cfg changes after index chg_at.
    task automatic send(input int n, input int last, input int chg_at, input logic [7:0] chg_len);
        for (int i = 0; i < n; i++) begin
            logic got;
            int   budget;
            got = 1'b0;
            budget = 0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = next_word;
            while (!got && budget < 500) begin
                @(negedge clk);
                got = s_axis_tready;
                @(posedge clk);
                #1;
                budget++;
            end
            total++;
            assert (got) else begin
                bad++;
                $error("FAIL send_timeout observed=%0d expected=1", got);
            end
            if (got) begin
                exp_q.push_back({(i == last), next_word});
                next_word = next_word + 16'd1;
                if (i == chg_at) cfg_pkt_len = chg_len;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && !(exp_q.size() == 0 && m_axis_tvalid === 1'b0); i++)
            @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", {31'd0, m_axis_tvalid}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_seq = 8'd0;
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        cfg_pkt_len = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
        chk("rst_tdata", {16'd0, m_axis_tdata}, 0);
        chk("rst_tlast", {31'd0, m_axis_tlast}, 0);
        chk("rst_pkt_done", {31'd0, pkt_done}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_s_tready", {31'd0, s_axis_tready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic framing: two packets of 4, back to back.
        cfg_pkt_len = 8'd4;
        next_word = 16'd1;
        cyc_q.delete();
        d0 = done_cnt;
        exp_hdr(8'd4);
        send(4, 3, -1, 8'd0);
        exp_hdr(8'd4);
        send(4, 3, -1, 8'd0);
        s_axis_tvalid = 1'b0;
        drain();
        chk("basic_xfers", cyc_q.size(), 10);
        if (cyc_q.size() == 10)
            chk("basic_no_bubble", cyc_q[9] - cyc_q[0], 9);
        chk("basic_done_pulses", done_cnt - d0, 2);

        // Backpressure: toggling downstream ready.
        do_reset();
        cfg_pkt_len = 8'd3;
        next_word = 16'h00a0;
        a0 = acc_cnt;
        bp_mode = 1'b1;
        exp_hdr(8'd3);
        send(3, 2, -1, 8'd0);
        s_axis_tvalid = 1'b0;
        drain();
        bp_mode = 1'b0;
        chk("bp_accepts", acc_cnt - a0, 3);

        // Zero length stalls; then length 1.
        do_reset();
        cfg_pkt_len = 8'd0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = next_word;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("zero_s_tready", {31'd0, s_axis_tready}, 0);
            chk("zero_m_tvalid", {31'd0, m_axis_tvalid}, 0);
        end
        @(posedge clk);
        #1;
        exp_hdr(8'd1);
        cfg_pkt_len = 8'd1;
        send(1, 0, -1, 8'd0);
        s_axis_tvalid = 1'b0;
        drain();

        // Reset mid-packet after 3 payload beats.
        do_reset();
        cfg_pkt_len = 8'd8;
        l0 = last_cnt;
        exp_hdr(8'd8);
        send(3, -1, -1, 8'd0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_seq = 8'd0;
        @(negedge clk);
        chk("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_queue", exp_q.size(), 0);
        chk("mid_no_orphan_tlast", last_cnt - l0, 0);
        @(posedge clk);
        #1;
        exp_hdr(8'd8);
        send(8, 7, -1, 8'd0);
        s_axis_tvalid = 1'b0;
        drain();

        // Config change mid-packet is ignored until the next header.
        do_reset();
        cfg_pkt_len = 8'd5;
        exp_hdr(8'd5);
        send(5, 4, 0, 8'd2);
        exp_hdr(8'd2);
        send(2, 1, -1, 8'd0);
        s_axis_tvalid = 1'b0;
        drain();

        // Sequence wrap: 257 single-beat packets.
        do_reset();
        cfg_pkt_len = 8'd1;
        l0 = last_cnt;
        d0 = done_cnt;
        for (int p = 0; p < 257; p++) begin
            exp_hdr(8'd1);
            send(1, 0, -1, 8'd0);
        end
        s_axis_tvalid = 1'b0;
        drain();
        chk("wrap_tlast_count", last_cnt - l0, 257);
        chk("wrap_done_count", done_cnt - d0, 257);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
